// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads Instruction_Memory and queues {pc, instr} for decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_controller #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          MEM_BYTES  = 16,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [63:0] inst_pc,
   output logic        fault,
   output logic [1:0]  state_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
`endif
);

   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = PW + 1;
   localparam logic [63:0] ADDR_MASK = 64'(MEM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      FAULT = 2'b10
   } state_t;

   state_t        state, state_next;
   logic [63:0]   pc;
   logic [31:0]   buf_data [FIFO_DEPTH];
   logic [63:0]   buf_pc   [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          pop, push, flush, misaligned;

   assign misaligned = (redirect_pc[1:0] != 2'b00);
   assign flush      = redirect & (state != FAULT);
   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready;
   assign push       = (state == FETCH) & ~redirect & ((count < CW'(FIFO_DEPTH)) | pop);
   assign imem_addr  = pc;
   assign inst_data  = buf_data[rd_ptr];
   assign inst_pc    = buf_pc[rd_ptr];
   assign state_o    = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = FETCH;
         FETCH:   if (redirect & misaligned) state_next = FAULT;
         FAULT:   state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         fault <= 1'b0;
         pc    <= RESET_PC & ADDR_MASK;
      end else begin
         state <= state_next;
         fault <= (state_next == FAULT);
         // A misaligned target leaves the PC where it was; only aligned redirects reload it.
         if (flush) begin
            if (!misaligned) pc <= redirect_pc & ADDR_MASK;
         end else if (push) begin
            pc <= (pc + 64'd4) & ADDR_MASK;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= pc;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   // Neither condition can occur in FAULT, so the counters freeze there naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (push) perf_fetched <= perf_fetched + 32'd1;
         if ((state == FETCH) && (count == CW'(FIFO_DEPTH)) && !pop)
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a 4-word instruction ROM model.
module tb_fetch_controller;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        fault;
   logic [1:0]  state_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] rom [4];
   assign rom[0] = 32'h02853403;
   assign rom[1] = 32'h009A84B3;
   assign rom[2] = 32'h00148493;
   assign rom[3] = 32'h02953423;
   assign imem_rdata = rom[imem_addr[3:2]];

   fetch_controller dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc),
      .fault       (fault),
      .state_o     (state_o)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_stalls (perf_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic s, input logic rdy, input logic redir, input logic [63:0] rpc);
      start       = s;
      inst_ready  = rdy;
      redirect    = redir;
      redirect_pc = rpc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0);
      #2;
      check_output("rst_state", 64'(state_o), 64'd0);
      check_output("rst_valid", 64'(inst_valid), 64'd0);
      check_output("rst_data", 64'(inst_data), 64'd0);
      check_output("rst_pc", inst_pc, 64'd0);
      check_output("rst_fault", 64'(fault), 64'd0);
      check_output("rst_addr", imem_addr, 64'd0);

      // Test 1: free-running fetch with wrap
      step();
      reset_n = 1'b1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0);
      step();
      check_output("t1_state_fetch", 64'(state_o), 64'd1);
      check_output("t1_valid_lat", 64'(inst_valid), 64'd0);
      step();
      check_output("t1_valid0", 64'(inst_valid), 64'd1);
      check_output("t1_pc0", inst_pc, 64'h0);
      check_output("t1_data0", 64'(inst_data), 64'h02853403);
      check_output("t1_addr", imem_addr, 64'h4);
      for (int k = 1; k < 4; k++) begin
         step();
         check_output("t1_valid", 64'(inst_valid), 64'd1);
         check_output("t1_pc", inst_pc, 64'(4 * k));
         check_output("t1_data", 64'(inst_data), 64'(rom[k]));
      end
      step();
      check_output("t1_wrap_pc", inst_pc, 64'h0);
      check_output("t1_wrap_data", 64'(inst_data), 64'h02853403);
      check_output("t1_addr_hi", imem_addr >> 4, 64'h0);

      // Test 2 (+6): backpressure stall then drain
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0);
      pulse_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0);
      step();
      step();
      check_output("t2_valid", 64'(inst_valid), 64'd1);
      step();
      check_output("t2_addr_full", imem_addr, 64'h8);
      for (int k = 0; k < 5; k++) step();
      check_output("t2_stall_pc", inst_pc, 64'h0);
      check_output("t2_stall_addr", imem_addr, 64'h8);
      check_output("t2_stall_valid", 64'(inst_valid), 64'd1);
`ifdef FETCH_PERF_EN
      check_output("t6_fetched", 64'(perf_fetched), 64'd2);
      check_output("t6_stalls", 64'(perf_stalls), 64'd5);
`endif
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0);
      #1;
      check_output("t2_beat0", inst_pc, 64'h0);
      step();
      check_output("t2_beat4", inst_pc, 64'h4);
      check_output("t2_beat4_data", 64'(inst_data), 64'h009A84B3);
      step();
      check_output("t2_beat8", inst_pc, 64'h8);
      check_output("t2_beat8_data", 64'(inst_data), 64'h00148493);

      // Test 3: redirect while full and ready
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0);
      pulse_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0);
      step();
      step();
      step();
      apply_stimulus(1'b1, 1'b1, 1'b1, 64'h8);
      step();
      check_output("t3_flush_valid", 64'(inst_valid), 64'd0);
      check_output("t3_flush_addr", imem_addr, 64'h8);
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0);
      step();
      check_output("t3_valid", 64'(inst_valid), 64'd1);
      check_output("t3_pc", inst_pc, 64'h8);
      check_output("t3_data", 64'(inst_data), 64'h00148493);
      step();
      check_output("t3_next_pc", inst_pc, 64'hC);
      check_output("t3_addr", imem_addr, 64'h0);

      // Test 4: misaligned redirect traps into FAULT
      apply_stimulus(1'b1, 1'b1, 1'b1, 64'h6);
      step();
      check_output("t4_state", 64'(state_o), 64'd2);
      check_output("t4_fault", 64'(fault), 64'd1);
      check_output("t4_valid", 64'(inst_valid), 64'd0);
      check_output("t4_pc_held", imem_addr, 64'h0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 4; k++) step();
      check_output("t4_stuck_state", 64'(state_o), 64'd2);
      check_output("t4_stuck_valid", 64'(inst_valid), 64'd0);
      reset_n = 1'b0;
      #1;
      check_output("t4_rst_fault", 64'(fault), 64'd0);
      check_output("t4_rst_state", 64'(state_o), 64'd0);

      // Test 5: asynchronous reset mid-burst
      reset_n = 1'b1;
      step();
      step();
      step();
      step();
      check_output("t5_burst_valid", 64'(inst_valid), 64'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check_output("t5_async_valid", 64'(inst_valid), 64'd0);
      check_output("t5_async_state", 64'(state_o), 64'd0);
      check_output("t5_async_addr", imem_addr, 64'h0);
      check_output("t5_async_pc", inst_pc, 64'h0);
      check_output("t5_async_data", 64'(inst_data), 64'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0);
      #2;
      reset_n = 1'b1;
      step();
      step();
      step();
      check_output("t5_idle_valid", 64'(inst_valid), 64'd0);
      check_output("t5_idle_state", 64'(state_o), 64'd0);
      check_output("t5_idle_addr", imem_addr, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
